// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg
//   Shared definitions for the round-robin packet arbiter:
//   - arb_state_e : arbiter FSM encoding (ST_IDLE, ST_LOCK)
//   - id_width()  : requester index width, max(1, clog2(n))
//   - DEF_NUM_REQ / DEF_DATA_W : default requester count and beat width
package rr_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;

    // A single requester still needs a 1-bit id field
    function automatic int id_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_pkt_arbiter_elastic_stage.sv
// elastic_stage
//   One-entry full-bandwidth ready/valid register slice. A full entry that
//   drains in a cycle can be refilled in that same cycle.
// Ports
//   clk, reset_n        clock, async active-low reset
//   in_srdy / in_rrdy   upstream valid / ready (in_rrdy = !full | out_rrdy)
//   in_data             payload captured on an accepted beat
//   out_srdy / out_rrdy downstream valid (= full) / ready
//   out_data            registered payload
module elastic_stage
    import rr_arb_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_srdy,
    input  logic [W-1:0] in_data,
    output logic         in_rrdy,
    output logic         out_srdy,
    output logic [W-1:0] out_data,
    input  logic         out_rrdy
);

    logic         full_r;
    logic [W-1:0] data_r;
    logic         accept_s;

    assign in_rrdy  = !full_r | out_rrdy;
    assign accept_s = in_srdy & in_rrdy;
    assign out_srdy = full_r;
    assign out_data = data_r;

    // Occupancy flag and payload register; payload holds while not accepting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_r <= 1'b0;
            data_r <= {W{1'b0}};
        end else begin
            if (accept_s) begin
                full_r <= 1'b1;
                data_r <= in_data;
            end else if (out_rrdy) begin
                full_r <= 1'b0;
                data_r <= data_r;
            end else begin
                full_r <= full_r;
                data_r <= data_r;
            end
        end
    end

endmodule

// File: rtl/rr_pkt_arbiter.sv
// rr_pkt_arbiter
//   Round-robin arbiter merging NUM_REQ ready/valid requesters onto one
//   registered output channel. A packet (beats up to and including in_last)
//   keeps the grant until its last beat, so packets never interleave.
// Ports
//   clk, reset_n  clock, async active-low reset
//   in_srdy       per-requester beat valid            [NUM_REQ]
//   in_data       requester i data at [i*DATA_W +: DATA_W]
//   in_last       per-requester last-beat flag        [NUM_REQ]
//   in_rrdy       per-requester ready, one-hot or zero [NUM_REQ]
//   out_srdy      output beat valid
//   out_data      output beat data                    [DATA_W]
//   out_last      output beat ends packet
//   out_id        source requester index              [ID_W]
//   out_rrdy      downstream ready
module rr_pkt_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        in_srdy,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    input  logic [NUM_REQ-1:0]        in_last,
    output logic [NUM_REQ-1:0]        in_rrdy,
    output logic                      out_srdy,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_rrdy
);

    localparam int PAY_W = DATA_W + 1 + ID_W;

    arb_state_e        state_r;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   lock_id_r;

    logic              grant_valid_s;
    logic              grant_hold_s;
    logic [ID_W-1:0]   grant_id_s;
    logic [DATA_W-1:0] mux_data_s;
    logic              mux_last_s;
    logic              stage_rdy_s;
    logic              accept_s;
    logic [PAY_W-1:0]  stage_in_s;
    logic [PAY_W-1:0]  stage_out_s;

    // Index following v, wrapping to zero after the last requester
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        if (int'(v) >= NUM_REQ - 1) begin
            return {ID_W{1'b0}};
        end else begin
            return v + ID_W'(1'b1);
        end
    endfunction

    // Rotating priority encoder: scan from ptr upward with wrap, or follow the lock
    always_comb begin
        int idx_v;
        grant_valid_s = 1'b0;
        grant_hold_s  = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        idx_v         = 0;
        if (state_r == ST_LOCK) begin
            // The lock owns the channel even while its source is idle
            grant_hold_s  = 1'b1;
            grant_id_s    = lock_id_r;
            grant_valid_s = in_srdy[lock_id_r];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx_v = int'(ptr_r) + k;
                if (idx_v >= NUM_REQ) begin
                    idx_v = idx_v - NUM_REQ;
                end else begin
                    idx_v = idx_v;
                end
                if (!grant_valid_s && in_srdy[idx_v]) begin
                    grant_valid_s = 1'b1;
                    grant_hold_s  = 1'b1;
                    grant_id_s    = ID_W'(idx_v);
                end else begin
                    grant_valid_s = grant_valid_s;
                end
            end
        end
    end

    // Data/last mux of the granted requester and one-hot ready back to it
    always_comb begin
        mux_data_s = {DATA_W{1'b0}};
        mux_last_s = 1'b0;
        in_rrdy    = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_s == ID_W'(i)) begin
                mux_data_s = in_data[i*DATA_W +: DATA_W];
                mux_last_s = in_last[i];
            end else begin
                mux_data_s = mux_data_s;
            end
        end
        if (grant_hold_s) begin
            in_rrdy[grant_id_s] = stage_rdy_s;
        end else begin
            in_rrdy = {NUM_REQ{1'b0}};
        end
    end

    assign accept_s   = grant_valid_s & stage_rdy_s;
    assign stage_in_s = {mux_last_s, grant_id_s, mux_data_s};

    // Arbiter FSM: pointer advances past the winner only on a packet's last beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= {ID_W{1'b0}};
            lock_id_r <= {ID_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && mux_last_s) begin
                        ptr_r <= wrap_inc(grant_id_s);
                    end else if (accept_s) begin
                        lock_id_r <= grant_id_s;
                        state_r   <= ST_LOCK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    if (accept_s && mux_last_s) begin
                        ptr_r   <= wrap_inc(lock_id_r);
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_LOCK;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    ptr_r     <= {ID_W{1'b0}};
                    lock_id_r <= {ID_W{1'b0}};
                end
            endcase
        end
    end

    elastic_stage #(
        .W(PAY_W)
    ) u_stage (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_srdy  (grant_valid_s),
        .in_data  (stage_in_s),
        .in_rrdy  (stage_rdy_s),
        .out_srdy (out_srdy),
        .out_data (stage_out_s),
        .out_rrdy (out_rrdy)
    );

    assign out_data = stage_out_s[DATA_W-1:0];
    assign out_id   = stage_out_s[DATA_W +: ID_W];
    assign out_last = stage_out_s[PAY_W-1];

endmodule
